// File: rtl/mtm_alu_serial_rx.sv
// mtm_alu_serial_rx: deserialises the one-wire sin frame stream into {B, A, op}.
// Each received packet is flagged for length, op-code and (optionally) CRC4
// errors and offered on a valid/ready port.
// Optional feature: define MTM_ALU_RX_CRC_CHECK_EN to build the CRC4 checker;
// without it err_crc is tied to 0 and the received crc field is ignored.
module mtm_alu_serial_rx #(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*DATA_BYTES-1:0] out_b,
  output logic [8*DATA_BYTES-1:0] out_a,
  output logic [2:0]              out_op,
  output logic [2:0]              out_err,
  output logic                    frame_err,
  output logic                    overrun
);

  localparam int unsigned W        = 8 * DATA_BYTES;
  localparam int unsigned NumBytes = 2 * DATA_BYTES;
  // Byte count saturates one above a full packet so over-length is still visible.
  localparam int unsigned CntW     = $clog2(NumBytes + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(NumBytes);
  localparam logic [CntW-1:0] CntSat  = CntW'(NumBytes + 1);

  typedef enum logic [2:0] {
    StResync,
    StIdle,
    StType,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic            type_q, type_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic [2*W-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // cmd_done_q marks the cycle after a good cmd stop bit; the packet is judged
  // and handed to the output register then, and packet state is cleared.
  logic            cmd_done_q, cmd_done_d;
  logic            ferr_pend_q, ferr_pend_d;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_b_q, out_b_d;
  logic [W-1:0]    out_a_q, out_a_d;
  logic [2:0]      out_op_q, out_op_d;
  logic [2:0]      out_err_q, out_err_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            err_crc;
  logic            err_op;
  logic            err_data;

  // Frame FSM and packet accumulation (shift register, byte count).
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    cmd_done_d  = 1'b0;
    ferr_pend_d = 1'b0;

    case (state_q)
      StResync: begin
        if (sin) state_d = StIdle;
      end
      StIdle: begin
        if (!sin) state_d = StType;
      end
      StType: begin
        type_d    = sin;
        bit_cnt_d = 3'd7;
        state_d   = StData;
      end
      StData: begin
        byte_d    = {byte_q[6:0], sin};
        bit_cnt_d = bit_cnt_q - 3'd1;
        if (bit_cnt_q == 3'd0) state_d = StStop;
      end
      StStop: begin
        if (sin) begin
          state_d = StIdle;
          if (type_q) begin
            cmd_done_d = 1'b1;
          end else begin
            shreg_d = {shreg_q[2*W-9:0], byte_q};
            if (cnt_q != CntSat) cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          // Bad stop bit: drop the partial packet and hunt for idle again.
          state_d     = StResync;
          ferr_pend_d = 1'b1;
          cnt_d       = '0;
          shreg_d     = '0;
        end
      end
      default: state_d = StResync;
    endcase

    // byte_q and shreg_q are still untouched here (next frame is at most in
    // its start bit), so they are read by the output stage before clearing.
    if (cmd_done_q) begin
      shreg_d = '0;
      cnt_d   = '0;
    end
  end

`ifdef MTM_ALU_RX_CRC_CHECK_EN
  logic [3:0] crc_q, crc_d;
  logic [3:0] crc_calc;
  logic [7:0] crc_tail;

  function automatic logic [3:0] crc_step(input logic [3:0] rem, input logic d);
    return {rem[2], rem[1], rem[3] ^ rem[0], rem[3] ^ d};
  endfunction

  // Running CRC over data bits; the cmd tail {1, op, 0000} is folded in at judgement.
  always_comb begin
    crc_d = crc_q;
    if (state_q == StData && !type_q) crc_d = crc_step(crc_q, sin);
    if (state_q == StStop && !sin) crc_d = '0;
    if (cmd_done_q) crc_d = '0;

    crc_tail = {1'b1, byte_q[6:4], 4'b0000};
    crc_calc = crc_q;
    for (int i = 7; i >= 0; i--) begin
      crc_calc = crc_step(crc_calc, crc_tail[i]);
    end
    err_crc = (crc_calc != byte_q[3:0]);
  end

  // CRC remainder register.
  always_ff @(posedge clk) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end
`else
  assign err_crc = 1'b0;
`endif

  // Legal ops are 000, 001, 100, 101: exactly those with op[1] clear.
  assign err_op   = byte_q[5];
  assign err_data = (cnt_q != CntFull);

  // Output register: load on a judged packet when empty or draining, else overrun.
  always_comb begin
    out_valid_d = out_valid_q;
    out_b_d     = out_b_q;
    out_a_d     = out_a_q;
    out_op_d    = out_op_q;
    out_err_d   = out_err_q;
    overrun_d   = 1'b0;
    frame_err_d = ferr_pend_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (cmd_done_q) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_b_d     = shreg_q[2*W-1:W];
        out_a_d     = shreg_q[W-1:0];
        out_op_d    = byte_q[6:4];
        out_err_d   = {err_op, err_crc, err_data};
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StResync;
      type_q      <= 1'b0;
      bit_cnt_q   <= '0;
      byte_q      <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      cmd_done_q  <= 1'b0;
      ferr_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_b_q     <= '0;
      out_a_q     <= '0;
      out_op_q    <= '0;
      out_err_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      cmd_done_q  <= cmd_done_d;
      ferr_pend_q <= ferr_pend_d;
      out_valid_q <= out_valid_d;
      out_b_q     <= out_b_d;
      out_a_q     <= out_a_d;
      out_op_q    <= out_op_d;
      out_err_q   <= out_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_b     = out_b_q;
  assign out_a     = out_a_q;
  assign out_op    = out_op_q;
  assign out_err   = out_err_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mtm_alu_serial_rx.sv
// Directed bench for mtm_alu_serial_rx with a packet scoreboard.
module tb_mtm_alu_serial_rx;

  localparam int unsigned DataBytes = 4;
  localparam int unsigned W         = 8 * DataBytes;

  typedef struct packed {
    logic [W-1:0] b;
    logic [W-1:0] a;
    logic [2:0]   op;
    logic [2:0]   err;
  } pkt_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b1;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [W-1:0] out_b;
  logic [W-1:0] out_a;
  logic [2:0]   out_op;
  logic [2:0]   out_err;
  logic         frame_err;
  logic         overrun;

  pkt_t         exp_q[$];
  logic [7:0]   txq[$];
  pkt_t         mon_p;
  int           checks = 0;
  int           failures = 0;
  int           ferr_seen = 0;
  int           ovr_seen = 0;

  mtm_alu_serial_rx #(.DATA_BYTES(DataBytes)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_a     (out_a),
    .out_op    (out_op),
    .out_err   (out_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC4 (x^4+x+1) as shift-and-reduce division.
  function automatic logic [3:0] lfsr(input logic [3:0] r, input logic d);
    logic fb;
    fb = r[3];
    return {r[2:0], d} ^ (fb ? 4'h3 : 4'h0);
  endfunction

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1;
    sin = b;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop,
                            input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int i = 0; i < gap; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
  endtask

  // Sends txq as data frames then a cmd frame; returns with the cmd stop bit on sin.
  task automatic send_pkt(input logic [2:0] op, input logic [3:0] crc_in, input bit good_crc,
                          input bit expect_out, input int max_gap);
    logic [2*W-1:0] sh;
    logic [3:0]     rem;
    logic [7:0]     by;
    logic [7:0]     tail;
    logic [3:0]     crc;
    logic           crc_bad;
    int             n;
    pkt_t           p;
    sh  = '0;
    rem = '0;
    n   = txq.size();
    for (int i = 0; i < n; i++) begin
      by = txq[i];
      sh = {sh[2*W-9:0], by};
      for (int k = 7; k >= 0; k--) rem = lfsr(rem, by[k]);
      send_frame(1'b0, by, 1'b1, max_gap);
    end
    tail = {1'b1, op, 4'b0000};
    for (int k = 7; k >= 0; k--) rem = lfsr(rem, tail[k]);
    crc = good_crc ? rem : crc_in;
`ifdef MTM_ALU_RX_CRC_CHECK_EN
    crc_bad = (crc != rem);
`else
    crc_bad = 1'b0;
`endif
    send_frame(1'b1, {1'b1, op, crc}, 1'b1, max_gap);
    txq.delete();
    p.b   = sh[2*W-1:W];
    p.a   = sh[W-1:0];
    p.op  = op;
    p.err = {(op != 3'b000 && op != 3'b001 && op != 3'b100 && op != 3'b101),
             crc_bad, (n != 2 * DataBytes)};
    if (expect_out) exp_q.push_back(p);
  endtask

  task automatic push_rand_bytes(input int n);
    for (int i = 0; i < n; i++) txq.push_back(8'($urandom_range(255, 0)));
  endtask

  // Scoreboard and pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) ferr_seen++;
      if (overrun) ovr_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          mon_p = exp_q.pop_front();
          chk("out_b", 64'(out_b), 64'(mon_p.b));
          chk("out_a", 64'(out_a), 64'(mon_p.a));
          chk("out_op", 64'(out_op), 64'(mon_p.op));
          chk("out_err", 64'(out_err), 64'(mon_p.err));
        end
      end
    end
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_out_b", 64'(out_b), 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero operands, AND, crc 0xB: check latency
    for (int i = 0; i < 8; i++) txq.push_back(8'h00);
    send_pkt(3'b000, 4'hB, 1'b0, 1'b1, 0);
    @(posedge clk); #1;
    chk("lat_valid_low_at_stop_edge", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_valid_high_next_edge", 64'(out_valid), 64'd1);
    repeat (3) @(posedge clk);

    // Bad crc 0x0
    for (int i = 0; i < 8; i++) txq.push_back(8'h00);
    send_pkt(3'b000, 4'h0, 1'b0, 1'b1, 0);

    // Illegal op 111 with correct crc 0x2
    for (int i = 0; i < 8; i++) txq.push_back(8'h00);
    send_pkt(3'b111, 4'h2, 1'b0, 1'b1, 0);

    // Seven data frames: short packet, then a clean one
    for (int i = 1; i <= 7; i++) txq.push_back(8'(8'h11 * i));
    send_pkt(3'b000, 4'hB, 1'b0, 1'b1, 1);
    push_rand_bytes(8);
    send_pkt(3'b101, 4'h0, 1'b1, 1'b1, 2);

    // Nine data frames: saturation keeps the last eight bytes
    push_rand_bytes(9);
    send_pkt(3'b001, 4'h0, 1'b1, 1'b1, 0);
    push_rand_bytes(8);
    send_pkt(3'b100, 4'h0, 1'b1, 1'b1, 0);

    // Framing error in the third data frame
    send_frame(1'b0, 8'hA1, 1'b1, 0);
    send_frame(1'b0, 8'hB2, 1'b1, 0);
    send_frame(1'b0, 8'hC3, 1'b0, 0);
    @(posedge clk); #1;
    sin = 1'b1;
    chk("ferr_low_at_stop_edge", 64'(frame_err), 64'd0);
    @(posedge clk); #1;
    chk("ferr_pulse", 64'(frame_err), 64'd1);
    @(posedge clk); #1;
    chk("ferr_one_cycle", 64'(frame_err), 64'd0);
    chk("ferr_no_valid", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    push_rand_bytes(8);
    send_pkt(3'b000, 4'h0, 1'b1, 1'b1, 0);

    // Reset mid-packet drops partial bytes silently
    send_frame(1'b0, 8'h5A, 1'b1, 0);
    send_frame(1'b0, 8'hA5, 1'b1, 0);
    send_frame(1'b0, 8'h3C, 1'b1, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_no_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    push_rand_bytes(8);
    send_pkt(3'b001, 4'h0, 1'b1, 1'b1, 1);
    repeat (4) @(posedge clk);

    // Overrun: first packet held, second dropped
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) txq.push_back(8'h00);
    send_pkt(3'b000, 4'hB, 1'b0, 1'b1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_first_held", 64'(out_valid), 64'd1);
    for (int i = 0; i < 8; i++) txq.push_back(8'h33);
    send_pkt(3'b100, 4'h0, 1'b1, 1'b0, 0);
    @(posedge clk); #1;
    chk("ovr_low_at_stop_edge", 64'(overrun), 64'd0);
    @(posedge clk); #1;
    chk("ovr_pulse", 64'(overrun), 64'd1);
    @(posedge clk); #1;
    chk("ovr_one_cycle", 64'(overrun), 64'd0);
    chk("ovr_held_valid", 64'(out_valid), 64'd1);
    chk("ovr_held_b", 64'(out_b), 64'd0);
    chk("ovr_held_a", 64'(out_a), 64'd0);
    chk("ovr_held_op", 64'(out_op), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ovr_drained_valid", 64'(out_valid), 64'd0);

    // Drain with a bounded wait, then totals
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("frame_err_total", 64'(ferr_seen), 64'd1);
    chk("overrun_total", 64'(ovr_seen), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtm_alu_serial_rx.md
# mtm_alu_serial_rx

Parametrised serial packet receiver for the mtm ALU family. It deserialises the one-wire `sin` frame stream into operand B, operand A and a command. It checks packet length, frame stop bits, op-code legality and, optionally, CRC4. Each packet is presented on a valid/ready output port to the ALU core. Operand width is generalised from the fixed 32-bit format to `DATA_BYTES` bytes per operand.

## Interface

- `DATA_BYTES`, default 4: bytes per operand; operand width W = 8*DATA_BYTES; legal range 1..8.
- `clk`  in  1: clock; all logic on posedge.
- `rst_n`  in  1: reset; one clock; reset is synchronous and active-low.
- `sin`  in  1: serial input, idle high, synchronous to `clk`, one bit per clock.
- `out_valid`  out  1: packet held in output register.
- `out_ready`  in  1: consumer accepts; transfer on posedge with `out_valid && out_ready`.
- `out_b`  out  W: operand B.
- `out_a`  out  W: operand A.
- `out_op`  out  3: op code.
- `out_err`  out  3: {err_op, err_crc, err_data}.
- `frame_err`  out  1: one-cycle pulse, stop bit sampled 0.
- `overrun`  out  1: one-cycle pulse, completed packet dropped because the output register was full.

## Operation

- Frame: 11 bits.
  - start 0, then type (0 = data, 1 = cmd), then 8 payload bits MSB first, then stop 1.
  - Gap between frames: 0 or more idle-high bits.
- Packet: 2*DATA_BYTES data frames, then one cmd frame.
  - Data frames carry B bytes MS byte first, then A bytes MS byte first.
  - Cmd payload = {1'b1, op[2:0], crc[3:0]}.
- FSM states:
  - RESYNC: entered on reset and on framing error; go to IDLE after sampling `sin`=1.
  - IDLE: `sin`=0 → TYPE.
  - TYPE: latch type bit → DATA.
  - DATA: 8 samples, bit counter 7→0 → STOP.
  - STOP: `sin`=1 → process frame, then IDLE. `sin`=0 → pulse `frame_err`, discard the partial packet (byte count = 0, CRC cleared), then RESYNC.
- Data frame processed: payload shifted into a 2W shift register ({B,A}); byte count increments, saturating at 2*DATA_BYTES+1.
- Cmd frame processed: packet complete. Flags:
  - err_data: byte count ≠ 2*DATA_BYTES. Operands are then the last 2*DATA_BYTES bytes received; missing bytes read 0.
  - err_op: op ∉ {000 AND, 001 OR, 100 ADD, 101 SUB}.
  - err_crc: see Configuration.
  - Flags are independent; several may be set.
- Packet state clears after every cmd frame.
- CRC4:
  - Polynomial x^4+x+1, init 0.
  - Computed over {B, A, 1'b1, op, 4'b0000}, MSB first.
  - Per-bit update rem = {rem[2], rem[1], rem[3]^rem[0], rem[3]^d}.
  - Data bits update incrementally as received.
- Output register:
  - Empty, or emptied in the same cycle: load the packet, `out_valid`=1.
  - Full and not being emptied: new packet dropped, `overrun` pulses, held packet unchanged.
  - Held outputs are stable while `out_valid && !out_ready`.
- Data frame arriving after cmd with count already saturated: counted; reported at the next cmd.

## Timing

- Reset values:
  - `out_valid`, `frame_err`, `overrun` = 0.
  - `out_a`, `out_b`, `out_op`, `out_err` = 0.
  - FSM = RESYNC; counters and CRC = 0.
- Latency: `out_valid` rises on the posedge after the one sampling the cmd stop bit.
- Back-to-back frames: a start bit sampled on the posedge immediately after a stop bit is accepted.
- `frame_err` and `overrun` are high for exactly one cycle, on the posedge after the offending stop bit.
- Reset mid-frame or mid-packet: everything is cleared at that edge; any partial packet is lost, with no error pulse.
- Reset overrides a simultaneous transfer.

## Configuration

- `MTM_ALU_RX_CRC_CHECK_EN` defined:
  - CRC4 is computed.
  - err_crc = (received crc ≠ computed).
- Undefined:
  - No CRC logic.
  - err_crc is always 0; the crc field is ignored.

## Test plan

- Reset, then DATA_BYTES=4, B=A=0, cmd 0x8B (AND, crc 0xB) → one cycle after the stop bit: `out_valid`=1, B=A=0, op=000, err=000.
- Same packet with cmd 0x80, CRC enabled → err=010. With CRC disabled → err=000.
- Zero operands, cmd 0xF2 (op 111, correct crc 0x2) → err=100 (op only).
- Seven data frames then cmd 0x8B → err_data set (err[0]=1). The following correct packet is clean.
- Stop bit forced 0 in the third data frame → `frame_err` one-cycle pulse, no `out_valid`. After `sin` is idle, a correct packet is received clean.
- `out_ready`=0 with two correct packets (second: B=A=0x33333333, ADD, crc from the reference model) → first packet held, `overrun` pulse at the end of the second. Raise `out_ready` → the first packet transfers, then `out_valid`=0.
